// File: rtl/player_r2r_pkg.sv
// Shared types and constants for the R2R audio player playback path.
package player_r2r_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      WAIT  = 2'd2,
      RUN   = 2'd3
   } player_state_t;

   localparam int         BUF_DEPTH     = 4096;
   localparam logic [7:0] DAC_IDLE      = 8'h80;
   localparam int         DIV_44K1_100M = 2267;
   // Smallest divisor that still leaves room for the prefetch read between ticks.
   localparam int         DIV_MIN       = 2;

endpackage

// File: rtl/player_r2r_rate_gen.sv
// Sample-rate prescaler: counts 0..div while enabled and emits a one-cycle tick
// on the terminal count. The divisor is used live and clamped to DIV_MIN.
module player_r2r_rate_gen
   import player_r2r_pkg::*;
#(
   parameter int DIV_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] presc_q;
   logic [DIV_W-1:0] presc_d;
   logic [DIV_W-1:0] div_eff;

   // Terminal-count compare and next count; >= lets a divisor lowered below the
   // current count fire at once instead of wrapping through the whole range.
   always_comb begin
      div_eff = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;
      tick    = en && (presc_q >= div_eff);
      presc_d = presc_q;
      if (clr) begin
         presc_d = '0;
      end else if (tick) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = presc_q + 1'b1;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/player_r2r_seq.sv
// Playback sequencer for the R2R audio player: reads the sample buffer one
// sample ahead, paces DAC updates with player_r2r_rate_gen and flags the half
// and end points of the window for ping-pong refill.
// Optional build macro: PLAYER_R2R_UNDERRUN_EN adds wr_level/underrun/rd_ack
// and stalls playback when the writer reports no valid samples.
module player_r2r_seq
   import player_r2r_pkg::*;
#(
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 8,
   parameter int                DIV_W      = 16,
   parameter logic [DATA_W-1:0] IDLE_LEVEL = DATA_W'(DAC_IDLE)
)(
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic              cfg_pause,
   input  logic              cfg_loop,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] dac,
   output logic              busy,
   output logic [ADDR_W:0]   pos,
   output logic              irq_half,
`ifdef PLAYER_R2R_UNDERRUN_EN
   input  logic [ADDR_W:0]   wr_level,
   output logic              underrun,
   output logic              rd_ack,
`endif
   output logic              irq_end
);

   player_state_t     state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              loop_q, loop_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [DATA_W-1:0] pref_q, pref_d;
   logic              rd_pend_q, rd_pend_d;
   logic [DATA_W-1:0] dac_q, dac_d;
   logic [ADDR_W:0]   pos_q, pos_d;
   logic              irq_half_q, irq_half_d;
   logic              irq_end_q, irq_end_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   logic              tick;
   logic              take;
   logic              deliver;
   logic              start_ok;
   logic              rate_en;
   logic              rate_clr;
   logic [ADDR_W:0]   idx_last;
   logic [ADDR_W:0]   idx_half;

   assign start_ok = cfg_start && (cfg_len != '0);
   assign idx_last = len_q - 1'b1;
   assign idx_half = len_q >> 1;
   assign rate_en  = (state_q == RUN) && !cfg_pause;
   assign rate_clr = (state_q != RUN);

   player_r2r_rate_gen #(
      .DIV_W (DIV_W)
   ) u_rate_gen (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .en    (rate_en),
      .clr   (rate_clr),
      .div   (cfg_div),
      .tick  (tick)
   );

`ifdef PLAYER_R2R_UNDERRUN_EN
   logic underrun_q, underrun_d;
   logic rd_ack_q, rd_ack_d;
   logic starved;

   assign take    = tick && (wr_level != '0);
   assign starved = tick && (wr_level == '0);

   // Sticky underrun flag (cleared by a fresh start) and per-sample consume ack.
   always_comb begin
      underrun_d = underrun_q;
      rd_ack_d   = deliver;
      if (start_ok) begin
         underrun_d = 1'b0;
      end else if (!cfg_stop && (state_q == RUN) && starved) begin
         underrun_d = 1'b1;
      end
   end

   // Underrun/ack registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         underrun_q <= 1'b0;
         rd_ack_q   <= 1'b0;
      end else begin
         underrun_q <= underrun_d;
         rd_ack_q   <= rd_ack_d;
      end
   end

   assign underrun = underrun_q;
   assign rd_ack   = rd_ack_q;
`else
   assign take = tick;
`endif

   // Next-state, sample delivery and read-ahead address generation.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      loop_d      = loop_q;
      idx_d       = idx_q;
      dac_d       = dac_q;
      pos_d       = pos_q;
      irq_half_d  = 1'b0;
      irq_end_d   = 1'b0;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      deliver     = 1'b0;
      // Read data lands one cycle after the strobe; capture it whenever it does.
      rd_pend_d   = mem_rd_en_q;
      pref_d      = rd_pend_q ? mem_rdata : pref_q;

      if (start_ok) begin
         base_d      = cfg_base;
         len_d       = cfg_len;
         loop_d      = cfg_loop;
         idx_d       = '0;
         mem_rd_en_d = 1'b1;
         mem_addr_d  = cfg_base;
         state_d     = PRIME;
      end else if (cfg_stop) begin
         state_d = IDLE;
         dac_d   = IDLE_LEVEL;
         pos_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            PRIME: begin
               state_d = WAIT;
            end
            WAIT: begin
               if (!cfg_pause) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (take) begin
                  deliver    = 1'b1;
                  dac_d      = pref_q;
                  pos_d      = idx_q;
                  irq_half_d = (idx_q == idx_half);
                  irq_end_d  = (idx_q == idx_last);
                  if ((idx_q == idx_last) && !loop_q) begin
                     // Final one-shot sample: dac keeps it until the next start.
                     state_d = IDLE;
                  end else begin
                     idx_d       = (idx_q == idx_last) ? '0 : idx_q + 1'b1;
                     mem_rd_en_d = 1'b1;
                     // Window may run past the top of the buffer; let it wrap.
                     mem_addr_d  = base_q + idx_d[ADDR_W-1:0];
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rd_pend_q   <= 1'b0;
         dac_q       <= IDLE_LEVEL;
         pos_q       <= '0;
         irq_half_q  <= 1'b0;
         irq_end_q   <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rd_pend_q   <= rd_pend_d;
         dac_q       <= dac_d;
         pos_q       <= pos_d;
         irq_half_q  <= irq_half_d;
         irq_end_q   <= irq_end_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   // Latched window config and prefetch sample; always written before use.
   always_ff @(posedge ACLK) begin
      base_q <= base_d;
      len_q  <= len_d;
      loop_q <= loop_d;
      pref_q <= pref_d;
   end

   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign dac       = dac_q;
   assign busy      = (state_q != IDLE);
   assign pos       = pos_q;
   assign irq_half  = irq_half_q;
   assign irq_end   = irq_end_q;

endmodule

// File: tb/tb_player_r2r_seq.sv
// Scoreboard bench for player_r2r_seq: expected DAC deliveries and buffer reads
// are queued when a run is started and compared as the DUT produces them.
module tb_player_r2r_seq;

   typedef struct {
      logic [7:0] dac;
      int         pos;
      bit         half;
      bit         endp;
      bit         busy;
      int         at;
   } exp_t;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        cfg_start, cfg_stop, cfg_pause, cfg_loop;
   logic [11:0] cfg_base;
   logic [12:0] cfg_len;
   logic [15:0] cfg_div;
   logic        mem_rd_en;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic [7:0]  dac;
   logic        busy;
   logic [12:0] pos;
   logic        irq_half, irq_end;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_deliv = 0;
   int          rd_total = 0;
   bit          mon_en = 1'b0;
   logic [7:0]  dac_prev = 8'h80;
   exp_t        dq[$];
   logic [11:0] rq[$];

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   // Buffer model: buffer[i] = i (low byte), data valid one cycle after strobe.
   always @(posedge ACLK) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

   player_r2r_seq dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_pause (cfg_pause),
      .cfg_loop  (cfg_loop),
      .cfg_base  (cfg_base),
      .cfg_len   (cfg_len),
      .cfg_div   (cfg_div),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .dac       (dac),
      .busy      (busy),
      .pos       (pos),
      .irq_half  (irq_half),
      .irq_end   (irq_end)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic monitor_step();
      exp_t        e;
      logic [11:0] ea;
      if (mon_en) begin
         if (mem_rd_en) begin
            rd_total++;
            if (rq.size() == 0) begin
               check_eq("rd_unexpected_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
               ea = rq.pop_front();
               check_eq("rd_addr", 32'(mem_addr), 32'(ea));
            end
         end
         if (dac != dac_prev) begin
            n_deliv++;
            if (dq.size() == 0) begin
               check_eq("dac_unexpected", 32'(dac), 32'hFFFF_FFFF);
            end else begin
               e = dq.pop_front();
               check_eq("dac_val", 32'(dac), 32'(e.dac));
               check_eq("dac_pos", 32'(pos), 32'(e.pos));
               check_eq("irq_half", 32'(irq_half), 32'(e.half));
               check_eq("irq_end", 32'(irq_end), 32'(e.endp));
               check_eq("busy_at_sample", 32'(busy), 32'(e.busy));
               if (e.at != 0) check_eq("dac_cycle", 32'(cyc), 32'(e.at));
            end
         end else if (irq_half || irq_end) begin
            check_eq("irq_spurious", 32'({irq_half, irq_end}), 32'd0);
         end
      end
      dac_prev = dac;
   endtask

   // Drive a start pulse and queue the expected deliveries/reads of the run.
   task automatic start_run(input int base, input int len, input int dv, input bit lp,
                            input int n, input int pause_after, input bit with_stop);
      int   deff, s, idx;
      bit   fin;
      exp_t e;
      @(posedge ACLK); #1;
      deff      = (dv < 2) ? 2 : dv;
      cfg_base  = 12'(base);
      cfg_len   = 13'(len);
      cfg_loop  = lp;
      cfg_div   = 16'(dv);
      cfg_start = 1'b1;
      cfg_stop  = with_stop;
      s         = cyc;
      rq.push_back(12'(base));
      for (int k = 0; k < n; k++) begin
         idx    = k % len;
         fin    = !lp && (idx == len - 1);
         e.dac  = 8'((base + idx) % 4096);
         e.pos  = idx;
         e.half = (idx == len / 2);
         e.endp = (idx == len - 1);
         e.busy = !fin;
         e.at   = s + 4 + deff + (deff + 1) * k + ((pause_after >= 0 && k > pause_after) ? 50 : 0);
         dq.push_back(e);
         if (!fin) rq.push_back(12'((base + (k + 1) % len) % 4096));
      end
      @(posedge ACLK); #1;
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
   endtask

   task automatic wait_deliv(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge ACLK);
         if (n_deliv >= target) break;
      end
      check_eq("deliv_reached", 32'(n_deliv >= target), 32'd1);
   endtask

   task automatic check_queues_empty();
      check_eq("dq_left", 32'(dq.size()), 32'd0);
      check_eq("rq_left", 32'(rq.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      ARESETN   = 1'b0;
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      cfg_pause = 1'b0;
      cfg_loop  = 1'b0;
      cfg_base  = '0;
      cfg_len   = '0;
      cfg_div   = 16'd9;
      fork
         forever begin
            @(negedge ACLK);
            monitor_step();
         end
      join_none

      // Reset state
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("rst_dac", 32'(dac), 32'h80);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_pos", 32'(pos), 32'd0);
      check_eq("rst_irq", 32'({irq_half, irq_end}), 32'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      mon_en  = 1'b1;

      // Idle for 100 cycles: no reads, midscale output
      repeat (100) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("idle_reads", 32'(rd_total), 32'd0);
      check_eq("idle_dac", 32'(dac), 32'h80);
      check_eq("idle_busy", 32'(busy), 32'd0);

      // One-shot window base 10, len 4, div 9
      n0 = n_deliv;
      start_run(10, 4, 9, 1'b0, 4, -1, 1'b0);
      wait_deliv(n0 + 4, 100);
      repeat (30) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("oneshot_hold_dac", 32'(dac), 32'd13);
      check_eq("oneshot_busy", 32'(busy), 32'd0);
      check_queues_empty();

      // Looped window wrapping past the top of the buffer, then stop
      n0 = n_deliv;
      start_run(4094, 4, 9, 1'b1, 9, -1, 1'b0);
      wait_deliv(n0 + 9, 200);
      mon_en = 1'b0;
      #1 cfg_stop = 1'b1;
      @(posedge ACLK); #1;
      cfg_stop = 1'b0;
      @(negedge ACLK);
      check_eq("stop_dac", 32'(dac), 32'h80);
      check_eq("stop_pos", 32'(pos), 32'd0);
      check_eq("stop_busy", 32'(busy), 32'd0);
      check_eq("stop_irq", 32'({irq_half, irq_end}), 32'd0);
      check_queues_empty();
      mon_en = 1'b1;

      // Pause for 50 cycles with the prescaler at 5 (div 9)
      n0 = n_deliv;
      start_run(0, 4, 9, 1'b0, 4, 1, 1'b0);
      wait_deliv(n0 + 2, 100);
      repeat (4) @(posedge ACLK);
      #1 cfg_pause = 1'b1;
      repeat (50) @(posedge ACLK);
      #1 cfg_pause = 1'b0;
      wait_deliv(n0 + 4, 200);
      check_queues_empty();

      // Start and stop together mid-play: restart from the new base
      n0 = n_deliv;
      start_run(100, 8, 9, 1'b1, 3, -1, 1'b0);
      wait_deliv(n0 + 3, 100);
      check_queues_empty();
      start_run(40, 3, 4, 1'b0, 3, -1, 1'b1);
      wait_deliv(n0 + 6, 100);
      check_queues_empty();

      // Divisor below the minimum is clamped
      n0 = n_deliv;
      start_run(50, 3, 1, 1'b0, 3, -1, 1'b0);
      wait_deliv(n0 + 3, 100);
      check_queues_empty();

      // Single-sample window: half and end pulse together
      n0 = n_deliv;
      start_run(7, 1, 9, 1'b0, 1, -1, 1'b0);
      wait_deliv(n0 + 1, 100);
      check_queues_empty();

      // Start with zero length is ignored
      @(posedge ACLK); #1;
      cfg_len   = '0;
      cfg_base  = 12'd300;
      cfg_start = 1'b1;
      @(posedge ACLK); #1;
      cfg_start = 1'b0;
      @(negedge ACLK);
      check_eq("len0_busy_now", 32'(busy), 32'd0);
      repeat (20) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("len0_busy_later", 32'(busy), 32'd0);
      check_eq("len0_dac", 32'(dac), 32'd7);

      // Asynchronous reset mid-play
      n0 = n_deliv;
      start_run(200, 8, 9, 1'b1, 2, -1, 1'b0);
      wait_deliv(n0 + 2, 100);
      mon_en = 1'b0;
      #3 ARESETN = 1'b0;
      #1;
      check_eq("arst_dac", 32'(dac), 32'h80);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_pos", 32'(pos), 32'd0);
      check_eq("arst_addr", 32'(mem_addr), 32'd0);
      check_eq("arst_rd_en", 32'(mem_rd_en), 32'd0);
      check_queues_empty();
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      mon_en = 1'b1;
      repeat (30) @(posedge ACLK);
      @(negedge ACLK);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      check_queues_empty();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
